safety_island_timer_unit: RTL
=============================

Name: safety_island_timer_unit

Overview:
- Core-local 32-bit timer peripheral, reached through the core-local regbus demux on the timer output port (base 0x0000_8000, range 0x5000).
- Each instance generates one compare interrupt and one overflow interrupt. NumTimers instances therefore supply the 2*NumTimers timer lines, which feed the lowest CLIC interrupt inputs.
- Registers are accessed through a single-cycle regbus slave.

Parameters:
- AddrWidth, 32, regbus address width; only addr[3:2] is decoded.
- DataWidth, 32, regbus data width; fixed at 32, other values are unsupported.
- PrescWidth, 8, width of the prescaler field and the prescaler counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- reg_valid_i  in  1  request valid
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  AddrWidth  byte address; offset within the block
- reg_wdata_i  in  32  write data
- reg_wstrb_i  in  4  byte strobes
- reg_ready_o  out  1  response ready
- reg_rdata_o  out  32  read data
- reg_error_o  out  1  access error
- irq_cmp_o  out  1  level compare interrupt
- irq_ovf_o  out  1  level overflow interrupt

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] CMP_IE, [3] OVF_IE, [8+:PrescWidth] PRESC. All other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 CMP: read/write. Reset value 0xFFFF_FFFF.
  - 0xC STATUS: [0] CMP_P, [1] OVF_P. Sticky; write-1-to-clear.
- Reset values: all registers 0 except CMP; prescaler counter 0; reg_ready_o=0, reg_rdata_o=0, reg_error_o=0, irq_cmp_o=0, irq_ovf_o=0.
- Regbus handshake:
  - reg_ready_o is combinationally equal to reg_valid_i. There is no wait state.
  - reg_rdata_o is combinational from register state, sampled in the same cycle.
  - Writes take effect at the next clock edge and honour reg_wstrb_i per byte.
  - Offsets with addr[AddrWidth-1:4] != 0 return reg_error_o=1 and rdata 0; writes to them are ignored.
  - When reg_valid_i=0, reg_rdata_o=0 and reg_error_o=0.
- Prescaler:
  - While EN=1, the prescaler counter increments every cycle.
  - When the prescaler counter equals PRESC, a tick is asserted and the prescaler counter returns to 0. A tick therefore occurs every PRESC+1 cycles; PRESC=0 gives a tick every cycle.
  - EN=0 holds COUNT and forces the prescaler counter to 0.
- On each tick, first matching rule applies:
  - COUNT==CMP and AUTO_RELOAD=1: COUNT<=0, CMP_P<=1. OVF_P is not set, even when CMP=0xFFFF_FFFF.
  - COUNT==CMP and AUTO_RELOAD=0: CMP_P<=1, then the remaining rules apply to COUNT.
  - COUNT==0xFFFF_FFFF: COUNT<=0 (wrap-around), OVF_P<=1.
  - Otherwise: COUNT<=COUNT+1.
- Simultaneous events:
  - A software write to COUNT in a tick cycle: the software value wins, and the prescaler counter is reset to 0 that cycle.
  - A software W1C of a STATUS bit in the same cycle the hardware sets it: the hardware set wins and the bit stays 1.
  - A write to CTRL that changes PRESC: takes effect from the next cycle. The prescaler counter is not reset. If the counter already exceeds the new PRESC, it counts up to 2^PrescWidth-1, wraps to 0, and then compares normally; no tick is generated at the wrap.
- Interrupts:
  - irq_cmp_o = CMP_P & CMP_IE and irq_ovf_o = OVF_P & OVF_IE, driven combinationally from registers.
  - Both are level-sensitive until the pending bit is cleared.
  - Clearing the IE bit masks the output but leaves the pending bit set.
- Reset mid-operation: asynchronous; all state returns to its reset value immediately, independent of the clock.

Test Plan:
- Reset, then read all 4 registers -> CTRL=0, COUNT=0, CMP=0xFFFF_FFFF, STATUS=0; every irq output 0; error 0.
- Write CMP=5, CTRL=0x7 (EN, AUTO_RELOAD, CMP_IE, PRESC=0) -> COUNT sequence 0,1,…,5,0; CMP_P and irq_cmp_o rise at the edge on which COUNT returns to 0, 6 cycles after EN is set; the sequence repeats. W1C STATUS=0x1 -> irq_cmp_o falls the next cycle.
- Write CTRL with PRESC=3, EN=1 -> COUNT increments once every 4 cycles; clearing EN freezes COUNT. Re-enabling gives the first increment 4 cycles later.
- Write COUNT=0xFFFF_FFFE, CTRL=0x9 (EN, OVF_IE, AUTO_RELOAD=0) with CMP left at reset 0xFFFF_FFFF -> after 2 ticks COUNT=0, OVF_P=1, CMP_P=1, irq_ovf_o=1.
- In the same cycle, issue W1C STATUS=0x1 while a compare match sets CMP_P -> CMP_P remains 1. In a tick cycle, write COUNT=0x100 -> COUNT reads 0x100.
- Read offset 0x10 -> reg_error_o=1, reg_rdata_o=0. Write CTRL with wstrb=0x1, wdata=0xFFFF_FFFF -> PRESC unchanged, bits [3:0]=0xF.

Source files
------------

// File: rtl/safety_island_timer_unit.sv
// Core-local 32-bit timer with prescaler, compare and overflow interrupts.
// Single-cycle regbus slave; register state drives both interrupt lines.
module safety_island_timer_unit #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned PrescWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [DataWidth-1:0]   reg_wdata_i,
    input  logic [DataWidth/8-1:0] reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [DataWidth-1:0]   reg_rdata_o,
    output logic                   reg_error_o,
    output logic                   irq_cmp_o,
    output logic                   irq_ovf_o
);

    localparam int unsigned NumBytes = DataWidth / 8;

    typedef logic [DataWidth-1:0]  word_t;
    typedef logic [PrescWidth-1:0] presc_t;

    function automatic word_t f_merge(
        input word_t               old_v,
        input word_t               new_v,
        input logic [NumBytes-1:0] strb
    );
        word_t res;
        res = old_v;
        for (int i = 0; i < NumBytes; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic   r_en;
    logic   r_auto;
    logic   r_cmp_ie;
    logic   r_ovf_ie;
    presc_t r_presc;
    presc_t r_psc;
    word_t  r_count;
    word_t  r_cmp;
    logic   r_cmp_p;
    logic   r_ovf_p;

    logic  w_in_range;
    logic  w_wr;
    logic  w_wr_ctrl;
    logic  w_wr_count;
    logic  w_wr_cmp;
    logic  w_wr_status;
    word_t w_ctrl_cur;
    word_t w_ctrl_wr;
    word_t w_cnt_nxt;
    logic  w_tick;
    logic  w_match;
    logic  w_set_cmp;
    logic  w_set_ovf;
    logic  w_clr_cmp;
    logic  w_clr_ovf;
    logic  w_unused;

    assign w_in_range  = (reg_addr_i[AddrWidth-1:4] == '0);
    assign w_wr        = reg_valid_i & reg_write_i & w_in_range;
    assign w_wr_ctrl   = w_wr & (reg_addr_i[3:2] == 2'd0);
    assign w_wr_count  = w_wr & (reg_addr_i[3:2] == 2'd1);
    assign w_wr_cmp    = w_wr & (reg_addr_i[3:2] == 2'd2);
    assign w_wr_status = w_wr & (reg_addr_i[3:2] == 2'd3);

    assign w_clr_cmp = w_wr_status & reg_wstrb_i[0] & reg_wdata_i[0];
    assign w_clr_ovf = w_wr_status & reg_wstrb_i[0] & reg_wdata_i[1];

    always_comb begin
        w_ctrl_cur                   = '0;
        w_ctrl_cur[0]                = r_en;
        w_ctrl_cur[1]                = r_auto;
        w_ctrl_cur[2]                = r_cmp_ie;
        w_ctrl_cur[3]                = r_ovf_ie;
        w_ctrl_cur[8 +: PrescWidth]  = r_presc;
    end

    assign w_ctrl_wr = f_merge(w_ctrl_cur, reg_wdata_i, reg_wstrb_i);
    assign w_unused  = ^{reg_addr_i[1:0], w_ctrl_wr[7:4],
                         w_ctrl_wr[DataWidth-1:8+PrescWidth]};

    assign w_tick  = r_en & (r_psc == r_presc);
    assign w_match = (r_count == r_cmp);

    // Auto-reload match takes priority over the wrap so it never flags overflow.
    always_comb begin
        w_cnt_nxt = r_count;
        w_set_cmp = 1'b0;
        w_set_ovf = 1'b0;
        if (w_tick) begin
            w_set_cmp = w_match;
            if (w_match && r_auto) begin
                w_cnt_nxt = '0;
            end else if (&r_count) begin
                w_cnt_nxt = '0;
                w_set_ovf = 1'b1;
            end else begin
                w_cnt_nxt = r_count + word_t'(1);
            end
        end
        if (w_wr_count) w_cnt_nxt = f_merge(r_count, reg_wdata_i, reg_wstrb_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_cmp_ie <= 1'b0;
            r_ovf_ie <= 1'b0;
            r_presc  <= '0;
            r_psc    <= '0;
            r_count  <= '0;
            r_cmp    <= '1;
            r_cmp_p  <= 1'b0;
            r_ovf_p  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= w_ctrl_wr[0];
                r_auto   <= w_ctrl_wr[1];
                r_cmp_ie <= w_ctrl_wr[2];
                r_ovf_ie <= w_ctrl_wr[3];
                r_presc  <= w_ctrl_wr[8 +: PrescWidth];
            end
            // Free-running wrap when PRESC is lowered below the counter.
            if (!r_en || w_tick) r_psc <= '0;
            else                 r_psc <= r_psc + presc_t'(1);
            r_count <= w_cnt_nxt;
            if (w_wr_cmp) r_cmp <= f_merge(r_cmp, reg_wdata_i, reg_wstrb_i);
            r_cmp_p <= (r_cmp_p & ~w_clr_cmp) | w_set_cmp;
            r_ovf_p <= (r_ovf_p & ~w_clr_ovf) | w_set_ovf;
        end
    end

    always_comb begin
        reg_rdata_o = '0;
        if (reg_valid_i && w_in_range) begin
            case (reg_addr_i[3:2])
                2'd0:    reg_rdata_o = w_ctrl_cur;
                2'd1:    reg_rdata_o = r_count;
                2'd2:    reg_rdata_o = r_cmp;
                default: reg_rdata_o = word_t'({r_ovf_p, r_cmp_p});
            endcase
        end
    end

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i & ~w_in_range;
    assign irq_cmp_o   = r_cmp_p & r_cmp_ie;
    assign irq_ovf_o   = r_ovf_p & r_ovf_ie;

endmodule
